ex_stage_mul: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; consumes the ID/EX bundle from the decode stage.
- Performs ALU ops, ALUSrc/RegDst muxing and branch-target add, then registers results into the EX/MEM pipeline register.
- Adds an iterative 32-cycle shift-add multiplier (R-type funct 011000) that stalls upstream while busy.
- Sits between the decode stage's ID/EX outputs and the memory stage.

---
 rtl/ex_stage_mul_if.sv | 42 ++++
 rtl/ex_stage_mul.sv | 152 +++++++++++++++
 tb/tb_ex_stage_mul.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_mul_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
// master drives the ID/EX side, slave is the execute stage.
interface ex_stage_mul_if #(
    parameter int WIDTH = 32
);
    logic             id_valid;
    logic             flush;
    logic [1:0]       wb_in;
    logic [2:0]       m_in;
    logic [3:0]       ex_in;
    logic [WIDTH-1:0] npc_in;
    logic [WIDTH-1:0] reg_rs_in;
    logic [WIDTH-1:0] reg_rt_in;
    logic [WIDTH-1:0] sign_ext_in;
    logic [4:0]       instr_20_16_in;
    logic [4:0]       instr_15_11_in;
    logic             stall;
    logic             valid_out;
    logic [1:0]       wb_out;
    logic [2:0]       m_out;
    logic [WIDTH-1:0] branch_target_out;
    logic             zero_out;
    logic [WIDTH-1:0] alu_result_out;
    logic [WIDTH-1:0] reg_rt_out;
    logic [4:0]       write_reg_out;

    modport master (
        output id_valid, flush, wb_in, m_in, ex_in, npc_in,
               reg_rs_in, reg_rt_in, sign_ext_in,
               instr_20_16_in, instr_15_11_in,
        input  stall, valid_out, wb_out, m_out, branch_target_out,
               zero_out, alu_result_out, reg_rt_out, write_reg_out
    );

    modport slave (
        input  id_valid, flush, wb_in, m_in, ex_in, npc_in,
               reg_rs_in, reg_rt_in, sign_ext_in,
               instr_20_16_in, instr_15_11_in,
        output stall, valid_out, wb_out, m_out, branch_target_out,
               zero_out, alu_result_out, reg_rt_out, write_reg_out
    );
endinterface

// File: rtl/ex_stage_mul.sv
// Execute stage: ALU, operand/destination muxing, branch target and
// an iterative shift-add multiplier that stalls upstream while busy.
module ex_stage_mul #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input logic          clk,
    input logic          rst,
    ex_stage_mul_if.slave bus
);
    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic             valid;
        logic [1:0]       wb;
        logic [2:0]       m;
        logic [WIDTH-1:0] bt;
        logic             zero;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] rt;
        logic [4:0]       wr;
    } exmem_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    exmem_t           out_q, out_d;

    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] bt;
    logic [4:0]       wr;
    logic             is_mul;
    logic             stall_c;

    assign alu_op = bus.ex_in[2:1];
    assign funct  = bus.sign_ext_in[5:0];
    assign op_b   = bus.ex_in[0] ? bus.sign_ext_in : bus.reg_rt_in;
    assign wr     = bus.ex_in[3] ? bus.instr_15_11_in
                                 : bus.instr_20_16_in;
    assign bt     = bus.npc_in + {bus.sign_ext_in[WIDTH-3:0], 2'b00};
    assign is_mul = bus.id_valid && alu_op == 2'b10
                    && funct == 6'b011000;

    // One multiplier bit per cycle; only the low word is kept.
    assign acc_nxt = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);

    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            alu_op == 2'b00,
            alu_op == 2'b11:
                alu_res = bus.reg_rs_in + op_b;
            alu_op == 2'b01:
                alu_res = bus.reg_rs_in - op_b;
            alu_op == 2'b10 && funct == 6'b100000:
                alu_res = bus.reg_rs_in + op_b;
            alu_op == 2'b10 && funct == 6'b100010:
                alu_res = bus.reg_rs_in - op_b;
            alu_op == 2'b10 && funct == 6'b100100:
                alu_res = bus.reg_rs_in & op_b;
            alu_op == 2'b10 && funct == 6'b100101:
                alu_res = bus.reg_rs_in | op_b;
            alu_op == 2'b10 && funct == 6'b101010:
                alu_res = {{(WIDTH-1){1'b0}},
                    $signed(bus.reg_rs_in) < $signed(op_b)};
            default:
                alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = '0;
        stall_c = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        stall_c = 1'b1;
                        a_d     = bus.reg_rs_in;
                        b_d     = bus.reg_rt_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else if (bus.id_valid) begin
                        out_d = '{1'b1, bus.wb_in, bus.m_in, bt,
                                  alu_res == '0, alu_res,
                                  bus.reg_rt_in, wr};
                    end
                end
                BUSY: begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        out_d   = '{1'b1, bus.wb_in, bus.m_in, bt,
                                    acc_nxt == '0, acc_nxt,
                                    bus.reg_rt_in, wr};
                    end else begin
                        stall_c = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign bus.stall             = stall_c & ~rst;
    assign bus.valid_out         = out_q.valid;
    assign bus.wb_out            = out_q.wb;
    assign bus.m_out             = out_q.m;
    assign bus.branch_target_out = out_q.bt;
    assign bus.zero_out          = out_q.zero;
    assign bus.alu_result_out    = out_q.res;
    assign bus.reg_rt_out        = out_q.rt;
    assign bus.write_reg_out     = out_q.wr;
endmodule

// File: tb/tb_ex_stage_mul.sv
// Bench for ex_stage_mul: directed and random ALU ops, multiplies,
// flush and asynchronous reset against an arithmetic reference model.
module tb_ex_stage_mul;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_stage_mul_if bus ();

    ex_stage_mul dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [107:0] model(
        input logic        v,
        input logic [1:0]  wb,
        input logic [2:0]  m,
        input logic [3:0]  ex,
        input logic [31:0] npc,
        input logic [31:0] rs,
        input logic [31:0] rt,
        input logic [31:0] imm,
        input logic [4:0]  r20,
        input logic [4:0]  r15
    );
        logic [31:0] b, r, tgt;
        if (!v) return '0;
        b = ex[0] ? imm : rt;
        case (ex[2:1])
            2'b01:   r = rs - b;
            2'b10: begin
                case (imm[5:0])
                    6'h20:   r = rs + b;
                    6'h22:   r = rs - b;
                    6'h24:   r = rs & b;
                    6'h25:   r = rs | b;
                    6'h2a:   r = ($signed(rs) < $signed(b)) ? 1 : 0;
                    6'h18:   r = rs * rt;
                    default: r = 0;
                endcase
            end
            default: r = rs + b;
        endcase
        tgt = npc + (imm << 2);
        return {1'b1, wb, m, tgt, r == 0, r, rt, ex[3] ? r15 : r20};
    endfunction

    function automatic logic [107:0] actual();
        return {bus.valid_out, bus.wb_out, bus.m_out,
                bus.branch_target_out, bus.zero_out,
                bus.alu_result_out, bus.reg_rt_out, bus.write_reg_out};
    endfunction

    task automatic drive(
        input logic        v,
        input logic [1:0]  wb,
        input logic [2:0]  m,
        input logic [3:0]  ex,
        input logic [31:0] npc,
        input logic [31:0] rs,
        input logic [31:0] rt,
        input logic [31:0] imm,
        input logic [4:0]  r20,
        input logic [4:0]  r15
    );
        bus.id_valid       = v;
        bus.wb_in          = wb;
        bus.m_in           = m;
        bus.ex_in          = ex;
        bus.npc_in         = npc;
        bus.reg_rs_in      = rs;
        bus.reg_rt_in      = rt;
        bus.sign_ext_in    = imm;
        bus.instr_20_16_in = r20;
        bus.instr_15_11_in = r15;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op: drive, clock once, compare the full EX/MEM word.
    task automatic op(
        input string       name,
        input logic        v,
        input logic [1:0]  wb,
        input logic [2:0]  m,
        input logic [3:0]  ex,
        input logic [31:0] npc,
        input logic [31:0] rs,
        input logic [31:0] rt,
        input logic [31:0] imm,
        input logic [4:0]  r20,
        input logic [4:0]  r15
    );
        logic [107:0] exp;
        drive(v, wb, m, ex, npc, rs, rt, imm, r20, r15);
        exp = model(v, wb, m, ex, npc, rs, rt, imm, r20, r15);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL %s stall got=%b want=0", name, bus.stall);
        end
        tick();
        checks++;
        if (actual() !== exp) begin
            failures++;
            $display("FAIL %s exmem got=%h want=%h", name, actual(), exp);
        end
    endtask

    // MULT presented in cycle 0 and held until the product appears.
    task automatic do_mult(
        input string       name,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [107:0] exp;
        logic [1:0]   wb;
        logic [2:0]   m;
        logic [4:0]   rd;
        int           nst;
        bit           done;
        wb = 2'($urandom_range(1, 3));
        m  = 3'($urandom);
        rd = 5'($urandom);
        drive(1'b1, wb, m, 4'b1100, 32'h400, a, b, 32'h0000_0018,
              5'd2, rd);
        exp = model(1'b1, wb, m, 4'b1100, 32'h400, a, b,
                    32'h0000_0018, 5'd2, rd);
        #1;
        nst  = (bus.stall === 1'b1) ? 1 : 0;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            tick();
            if (k == 1) begin
                checks++;
                if ({bus.valid_out, bus.wb_out, bus.m_out} !== 6'd0) begin
                    failures++;
                    $display("FAIL %s bubble got=%b want=0", name,
                             {bus.valid_out, bus.wb_out, bus.m_out});
                end
            end
            if (bus.stall === 1'b1) nst++;
            else done = 1'b1;
        end
        checks++;
        if (!done || nst != 32) begin
            failures++;
            $display("FAIL %s stall_cycles got=%0d want=32", name, nst);
        end
        tick();
        checks++;
        if (actual() !== exp) begin
            failures++;
            $display("FAIL %s product got=%h want=%h", name, actual(), exp);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.flush = 1'b0;
        drive(1'b1, 2'b11, 3'b111, 4'b1100, 32'h100, 32'h5, 32'h7,
              32'h18, 5'd1, 5'd2);
        #2;
        checks++;
        if (actual() !== 108'd0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset got=%h stall=%b want=0", actual(),
                     bus.stall);
        end
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b11, 3'b111, 4'b1100, 32'h100, 32'h5, 32'h7,
              32'h18, 5'd1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (actual() !== 108'd0 || bus.stall !== 1'b0) begin
                failures++;
                $display("FAIL idle_bubble got=%h stall=%b want=0",
                         actual(), bus.stall);
            end
        end
    endtask

    task automatic test_directed();
        op("add", 1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd5, 32'd7,
           32'h20, 5'd9, 5'd3);
        checks++;
        if (bus.alu_result_out !== 32'd12 || bus.write_reg_out !== 5'd3
            || bus.zero_out !== 1'b0 || bus.valid_out !== 1'b1) begin
            failures++;
            $display("FAIL add_fields res=%h wr=%0d z=%b v=%b want=c/3/0/1",
                     bus.alu_result_out, bus.write_reg_out,
                     bus.zero_out, bus.valid_out);
        end
        op("beq", 1, 2'b00, 3'b100, 4'b0010, 32'h100, 32'd9, 32'd9,
           32'd4, 5'd0, 5'd0);
        checks++;
        if (bus.zero_out !== 1'b1 || bus.branch_target_out !== 32'h110) begin
            failures++;
            $display("FAIL beq_fields z=%b bt=%h want=1/110",
                     bus.zero_out, bus.branch_target_out);
        end
        op("slt_neg", 1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF,
           32'd1, 32'h2a, 5'd0, 5'd4);
        checks++;
        if (bus.alu_result_out !== 32'd1) begin
            failures++;
            $display("FAIL slt_neg_res got=%h want=1", bus.alu_result_out);
        end
        op("slt_swap", 1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd1,
           32'hFFFF_FFFF, 32'h2a, 5'd0, 5'd4);
        op("lw", 1, 2'b11, 3'b010, 4'b0001, 32'h0, 32'h1000, 32'h55,
           32'hFFFF_FFFC, 5'd8, 5'd17);
        checks++;
        if (bus.alu_result_out !== 32'h0FFC || bus.write_reg_out !== 5'd8)
        begin
            failures++;
            $display("FAIL lw_fields res=%h wr=%0d want=ffc/8",
                     bus.alu_result_out, bus.write_reg_out);
        end
        op("bad_funct", 1, 2'b10, 3'b001, 4'b1100, 32'h0, 32'd3, 32'd4,
           32'h3f, 5'd1, 5'd6);
    endtask

    task automatic test_random_alu();
        logic [5:0] fl [6];
        logic [5:0] f;
        logic [3:0] ex;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
        for (int i = 0; i < 60; i++) begin
            f = fl[$urandom_range(0, 5)];
            if (f == 6'h00) f = 6'($urandom);
            if (f == 6'h18) f = 6'h3f;
            ex = 4'($urandom);
            op("rand_alu", ($urandom_range(0, 7) != 0), 2'($urandom),
               3'($urandom), ex, $urandom,
               ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
               $urandom, {26'($urandom), f}, 5'($urandom),
               5'($urandom));
        end
    endtask

    task automatic test_mult();
        do_mult("mul_basic", 32'h0001_2345, 32'h0000_0100);
        checks++;
        if (bus.alu_result_out !== 32'h0123_4500) begin
            failures++;
            $display("FAIL mul_basic_res got=%h want=01234500",
                     bus.alu_result_out);
        end
        do_mult("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (bus.alu_result_out !== 32'd1) begin
            failures++;
            $display("FAIL mul_ones_res got=%h want=1", bus.alu_result_out);
        end
        do_mult("mul_zero", 32'h8000_0000, 32'h2);
        for (int i = 0; i < 4; i++) do_mult("mul_rand", $urandom, $urandom);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        do_mult("b2b_first", 32'd1234567, 32'd7654321);
        do_mult("b2b_second", 32'hDEAD_BEEF, 32'h0000_1001);
        op("b2b_after", 1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd40,
           32'd2, 32'h20, 5'd0, 5'd5);
    endtask

    task automatic test_flush();
        drive(1'b1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h77, 32'h99,
              32'h18, 5'd0, 5'd7);
        for (int k = 0; k < 10; k++) tick();
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy_stall got=%b want=0", bus.stall);
        end
        tick();
        bus.flush = 1'b0;
        checks++;
        if (actual() !== 108'd0) begin
            failures++;
            $display("FAIL flush_busy_bubble got=%h want=0", actual());
        end
        do_mult("flush_restart", 32'h77, 32'h99);
        bus.flush = 1'b1;
        drive(1'b1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h5, 32'h6,
              32'h18, 5'd0, 5'd7);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_stall got=%b want=0", bus.stall);
        end
        tick();
        bus.flush = 1'b0;
        checks++;
        if (actual() !== 108'd0) begin
            failures++;
            $display("FAIL flush_idle_bubble got=%h want=0", actual());
        end
        do_mult("flush_idle_next", 32'h5, 32'h6);
    endtask

    task automatic test_async_reset();
        op("pre_rst", 1, 2'b11, 3'b000, 4'b0001, 32'h40, 32'h10,
           32'h0, 32'h8, 5'd9, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (actual() !== 108'd0) begin
            failures++;
            $display("FAIL async_rst_out got=%h want=0", actual());
        end
        #1;
        rst = 1'b0;
        drive(1'b1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h3, 32'h5,
              32'h18, 5'd0, 5'd7);
        for (int k = 0; k < 15; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || actual() !== 108'd0) begin
            failures++;
            $display("FAIL async_rst_mul stall=%b out=%h want=0",
                     bus.stall, actual());
        end
        tick();
        rst = 1'b0;
        do_mult("after_rst", 32'h3, 32'h5);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_alu();
        test_mult();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
